scenario_loader: RTL and testbench
==================================

SCENARIO_LOADER -- requirements
Module: scenario_loader

Interface
REQ-001 Param SPRITES, default 9, number of sprites per frame.
REQ-002 Param WIDTH, default 32, location/velocity word width; mass is WIDTH/2 bits.
REQ-003 Param DIMENSIONS, default 2, axes per sprite.
REQ-004 Param TIMEOUT, default 1_620_000, maximum idle cycles between bytes inside a frame.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk_162  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rx_data  in  8  incoming frame byte.
REQ-009 rx_valid  in  1  rx_data valid.
REQ-010 rx_ready  out  1  byte accepted when rx_valid && rx_ready.
REQ-011 init_locations  out  [SPRITES][DIMENSIONS][WIDTH]  committed start positions.
REQ-012 init_velos  out  [SPRITES][DIMENSIONS][WIDTH]  committed start velocities.
REQ-013 masses  out  [SPRITES][WIDTH/2]  committed masses.
REQ-014 radii  out  [SPRITES][7]  committed radii.
REQ-015 data_ready  out  1  one-cycle pulse: new scenario valid on outputs.
REQ-016 frame_error  out  1  one-cycle pulse: bad checksum or timeout.
REQ-017 busy  out  1  high while in any state other than IDLE.

Function
REQ-018 Frame format SHALL be: header 0xA5, then per sprite 0..SPRITES-1: loc[0], loc[1], velo[0], velo[1] (WIDTH/8 bytes each), mass (WIDTH/16 bytes), radius (1 byte, bit 7 ignored), then 1 checksum byte.
REQ-019 Multi-byte fields SHALL be little-endian; per-sprite byte count BPS = 2*DIMENSIONS*WIDTH/8 + WIDTH/16 + 1 (19 at defaults).
REQ-020 Checksum SHALL equal XOR of all payload bytes, header and checksum excluded.
REQ-021 States: IDLE, PAYLOAD, CKSUM, COMMIT.
REQ-022 IDLE: rx_ready=1; accepted 0xA5 -> PAYLOAD, clear counters and XOR; any other byte discarded.
REQ-023 PAYLOAD: rx_ready=1; each accepted byte written to shadow registers at (sprite_idx, byte_idx), XOR updated; after byte BPS-1 of sprite SPRITES-1 -> CKSUM.
REQ-024 CKSUM: rx_ready=1; accepted byte equal to running XOR -> COMMIT; mismatch -> frame_error=1 next cycle, -> IDLE, outputs unchanged.
REQ-025 COMMIT: lasts exactly one cycle, rx_ready=0, shadow copied to all outputs, data_ready=1 in this same cycle, -> IDLE.
REQ-026 Latency: checksum byte accepted at edge N -> outputs updated and data_ready high for cycle N+1 only.
REQ-027 Outputs SHALL hold last committed values indefinitely; they change only in COMMIT or reset.
REQ-028 A 0xA5 byte inside PAYLOAD/CKSUM SHALL be treated as data, never a resync.
REQ-029 Gap counter SHALL clear on every accepted byte and on entry to PAYLOAD; in PAYLOAD/CKSUM, reaching TIMEOUT-1 with no handshake -> frame_error pulse, -> IDLE, shadow discarded.
REQ-030 Handshake in the same cycle as timeout SHALL win: byte accepted, no error.
REQ-031 Gap counter SHALL be $clog2(TIMEOUT+1) bits, saturating, inactive in IDLE.
REQ-032 data_ready and frame_error SHALL never be high in the same cycle.

Reset
REQ-033 rst SHALL force IDLE, all outputs 0 (rx_ready 1 the following cycle), shadow, XOR, indices and gap counter cleared.
REQ-034 rst mid-frame SHALL abandon the frame with no data_ready or frame_error pulse.

Structure
REQ-035 Shared package physics_pkg SHALL hold the state enum, HEADER=8'hA5 and the BPS/field-offset localparam functions.
REQ-036 Implemented as a single module; no sub-module; shadow registers separate from output registers.

Verification (SPRITES=2, WIDTH=32, DIMENSIONS=2, TIMEOUT=100)
REQ-037 Valid frame: 0xA5, sprite0 loc={0x00000100,0x00000200}, velo={0xFFFFFFF0,0x10}, mass 0x0C00, radius 0x08, sprite1 all 0x11 bytes, correct XOR -> data_ready exactly 1 cycle after checksum byte, init_locations[0][0]=0x00000100, init_velos[0][0]=0xFFFFFFF0, masses[1]=0x1111, radii[1]=0x11.
REQ-038 Same frame with checksum ^0x01 -> frame_error 1-cycle pulse, no data_ready, outputs keep previous values.
REQ-039 Bytes 0x00,0x37 before header, then rx_valid toggled 50% mid-frame -> leading bytes ignored, frame committed correctly.
REQ-040 Stop after 10 payload bytes, idle 100 cycles -> frame_error pulse, busy 0; following valid frame commits normally.
REQ-041 rst asserted at payload byte 20 -> outputs 0, no pulses, busy 0; next valid frame commits.
REQ-042 Byte accepted on the exact timeout cycle -> no frame_error; frame completes.

Source files
------------

// File: rtl/physics_pkg.sv
// Shared definitions for the scenario loader: FSM states, frame header and
// byte-offset helpers describing one sprite record inside a frame.
package physics_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_COMMIT
  } state_e;

  localparam logic [7:0] HEADER = 8'hA5;

  // Per-sprite record: loc[0..D-1], velo[0..D-1], mass, radius (all little-endian).
  function automatic int bps(input int width, input int dims);
    return 2 * dims * width / 8 + width / 16 + 1;
  endfunction

  function automatic int loc_off(input int d, input int width);
    return d * width / 8;
  endfunction

  function automatic int velo_off(input int d, input int dims, input int width);
    return (dims + d) * width / 8;
  endfunction

  function automatic int mass_off(input int dims, input int width);
    return 2 * dims * width / 8;
  endfunction

  function automatic int radius_off(input int dims, input int width);
    return 2 * dims * width / 8 + width / 16;
  endfunction

endpackage

// File: rtl/scenario_loader.sv
// Parses byte-stream scenario frames into shadow registers and commits them
// to the outputs in one cycle once the XOR checksum matches.
module scenario_loader
  import physics_pkg::*;
#(
  parameter int SPRITES    = 9,
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2,
  parameter int TIMEOUT    = 1_620_000
) (
  input  logic                                            clk_162,
  input  logic                                            rst,
  input  logic [7:0]                                      rx_data,
  input  logic                                            rx_valid,
  output logic                                            rx_ready,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]   init_locations,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]   init_velos,
  output logic [SPRITES-1:0][WIDTH/2-1:0]                 masses,
  output logic [SPRITES-1:0][6:0]                         radii,
  output logic                                            data_ready,
  output logic                                            frame_error,
  output logic                                            busy
);

  localparam int BPS = bps(WIDTH, DIMENSIONS);
  localparam int SW  = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam int BW  = $clog2(BPS);
  localparam int GW  = $clog2(TIMEOUT + 1);
  localparam int MOFF = mass_off(DIMENSIONS, WIDTH);
  localparam int ROFF = radius_off(DIMENSIONS, WIDTH);

  state_e                                        state_q, state_d;
  logic [SW-1:0]                                 sprite_idx_q, sprite_idx_d;
  logic [BW-1:0]                                 byte_idx_q, byte_idx_d;
  logic [7:0]                                    xor_q, xor_d;
  logic [GW-1:0]                                 gap_q, gap_d;
  logic                                          frame_error_q, frame_error_d;
  logic [SPRITES-1:0][BPS*8-1:0]                 shadow_q, shadow_d;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] loc_q, loc_d;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] velo_q, velo_d;
  logic [SPRITES-1:0][WIDTH/2-1:0]               mass_q, mass_d;
  logic [SPRITES-1:0][6:0]                       radius_q, radius_d;

  logic accept;
  logic in_frame;
  logic timeout;
  logic load_out;

  always_comb begin
    state_d       = state_q;
    sprite_idx_d  = sprite_idx_q;
    byte_idx_d    = byte_idx_q;
    xor_d         = xor_q;
    gap_d         = '0;
    frame_error_d = 1'b0;
    shadow_d      = shadow_q;
    load_out      = 1'b0;

    rx_ready = ~rst && (state_q != ST_COMMIT);
    accept   = rx_valid && rx_ready;
    in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);
    timeout  = in_frame && !accept && (gap_q >= GW'(TIMEOUT - 1));

    if (in_frame && !accept && (gap_q != GW'(TIMEOUT))) begin
      gap_d = gap_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == HEADER)) begin
          state_d      = ST_PAYLOAD;
          sprite_idx_d = '0;
          byte_idx_d   = '0;
          xor_d        = '0;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          shadow_d[sprite_idx_q][{byte_idx_q, 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          if (byte_idx_q == BW'(BPS - 1)) begin
            byte_idx_d = '0;
            if (sprite_idx_q == SW'(SPRITES - 1)) begin
              state_d = ST_CKSUM;
            end else begin
              sprite_idx_d = sprite_idx_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if (timeout) begin
          state_d       = ST_IDLE;
          frame_error_d = 1'b1;
        end
      end
      ST_CKSUM: begin
        if (accept) begin
          if (rx_data == xor_q) begin
            state_d  = ST_COMMIT;
            load_out = 1'b1;
          end else begin
            state_d       = ST_IDLE;
            frame_error_d = 1'b1;
          end
        end else if (timeout) begin
          state_d       = ST_IDLE;
          frame_error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs load on the checksum edge so they are already valid in COMMIT.
  always_comb begin
    loc_d    = loc_q;
    velo_d   = velo_q;
    mass_d   = mass_q;
    radius_d = radius_q;
    if (load_out) begin
      for (int s = 0; s < SPRITES; s++) begin
        for (int d = 0; d < DIMENSIONS; d++) begin
          loc_d[s][d]  = shadow_q[s][loc_off(d, WIDTH)*8 +: WIDTH];
          velo_d[s][d] = shadow_q[s][velo_off(d, DIMENSIONS, WIDTH)*8 +: WIDTH];
        end
        mass_d[s]   = shadow_q[s][MOFF*8 +: WIDTH/2];
        radius_d[s] = 7'(shadow_q[s][ROFF*8 +: 8]);
      end
    end
  end

  always_ff @(posedge clk_162) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sprite_idx_q  <= '0;
      byte_idx_q    <= '0;
      xor_q         <= '0;
      gap_q         <= '0;
      frame_error_q <= 1'b0;
      shadow_q      <= '0;
      loc_q         <= '0;
      velo_q        <= '0;
      mass_q        <= '0;
      radius_q      <= '0;
    end else begin
      state_q       <= state_d;
      sprite_idx_q  <= sprite_idx_d;
      byte_idx_q    <= byte_idx_d;
      xor_q         <= xor_d;
      gap_q         <= gap_d;
      frame_error_q <= frame_error_d;
      shadow_q      <= shadow_d;
      loc_q         <= loc_d;
      velo_q        <= velo_d;
      mass_q        <= mass_d;
      radius_q      <= radius_d;
    end
  end

  assign init_locations = loc_q;
  assign init_velos     = velo_q;
  assign masses         = mass_q;
  assign radii          = radius_q;
  assign data_ready     = (state_q == ST_COMMIT);
  assign frame_error    = frame_error_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scenario_loader.sv
// Drives scenario frames (directed and random) into scenario_loader and checks
// pulses and committed fields against a frame-level reference model.
module tb_scenario_loader;

  localparam int SPRITES = 2;
  localparam int WIDTH   = 32;
  localparam int DIMS    = 2;
  localparam int TIMEOUT = 100;
  localparam int BPS     = 19;
  localparam int NPAY    = SPRITES * BPS;

  logic                                      clk_162;
  logic                                      rst;
  logic [7:0]                                rx_data;
  logic                                      rx_valid;
  logic                                      rx_ready;
  logic [SPRITES-1:0][DIMS-1:0][WIDTH-1:0]   init_locations;
  logic [SPRITES-1:0][DIMS-1:0][WIDTH-1:0]   init_velos;
  logic [SPRITES-1:0][WIDTH/2-1:0]           masses;
  logic [SPRITES-1:0][6:0]                   radii;
  logic                                      data_ready;
  logic                                      frame_error;
  logic                                      busy;

  scenario_loader #(
    .SPRITES(SPRITES), .WIDTH(WIDTH), .DIMENSIONS(DIMS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_162(clk_162), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .init_locations(init_locations), .init_velos(init_velos),
    .masses(masses), .radii(radii), .data_ready(data_ready),
    .frame_error(frame_error), .busy(busy)
  );

  initial clk_162 = 1'b0;
  always #5 clk_162 = ~clk_162;

  int n_checks = 0;
  int n_fail   = 0;
  int dr_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int exp_dr = 0, exp_fe = 0;

  logic [7:0]  pay [NPAY];
  int          gaps [NPAY+1];
  logic [31:0] m_loc  [SPRITES][DIMS];
  logic [31:0] m_velo [SPRITES][DIMS];
  logic [15:0] m_mass [SPRITES];
  logic [6:0]  m_rad  [SPRITES];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_162) begin
    if (data_ready) dr_cnt++;
    if (frame_error) fe_cnt++;
    if (data_ready && frame_error) both_cnt++;
  end

  function automatic logic [31:0] field(input int s, input int off, input int nb);
    logic [31:0] v = '0;
    for (int k = 0; k < nb; k++) v = v | (32'(pay[s*BPS + off + k]) << (8 * k));
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SPRITES; s++) begin
      for (int d = 0; d < DIMS; d++) begin
        m_loc[s][d] = '0;
        m_velo[s][d] = '0;
      end
      m_mass[s] = '0;
      m_rad[s]  = '0;
    end
  endtask

  // Record layout: loc0 @0, loc1 @4, velo0 @8, velo1 @12, mass @16, radius @18.
  task automatic model_commit();
    for (int s = 0; s < SPRITES; s++) begin
      for (int d = 0; d < DIMS; d++) begin
        m_loc[s][d]  = field(s, 4 * d, 4);
        m_velo[s][d] = field(s, 8 + 4 * d, 4);
      end
      m_mass[s] = 16'(field(s, 16, 2));
      m_rad[s]  = 7'(field(s, 18, 1) & 32'h7f);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int s = 0; s < SPRITES; s++) begin
      for (int d = 0; d < DIMS; d++) begin
        check($sformatf("%s_loc%0d%0d", tag, s, d), init_locations[s][d], m_loc[s][d]);
        check($sformatf("%s_velo%0d%0d", tag, s, d), init_velos[s][d], m_velo[s][d]);
      end
      check($sformatf("%s_mass%0d", tag, s), masses[s], m_mass[s]);
      check($sformatf("%s_rad%0d", tag, s), radii[s], m_rad[s]);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk_162);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_162);
    while (!rx_ready && w < 20) begin
      @(negedge clk_162);
      w++;
    end
    if (!rx_ready) check("rx_ready_wait", rx_ready, 1'b1);
    @(posedge clk_162);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic random_payload();
    for (int i = 0; i < NPAY; i++) pay[i] = 8'($urandom);
    pay[$urandom_range(0, NPAY - 1)] = 8'hA5;
  endtask

  task automatic set_gaps(input int maxgap);
    for (int i = 0; i <= NPAY; i++) gaps[i] = $urandom_range(0, maxgap);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] flip);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NPAY; i++) x = x ^ pay[i];
    send_byte(8'hA5);
    for (int i = 0; i < NPAY; i++) begin
      idle(gaps[i]);
      send_byte(pay[i]);
    end
    idle(gaps[NPAY]);
    send_byte(x ^ flip);
    if (flip == 8'h00) begin
      check({tag, "_dr"}, data_ready, 1'b1);
      check({tag, "_fe"}, frame_error, 1'b0);
      model_commit();
      exp_dr++;
    end else begin
      check({tag, "_fe"}, frame_error, 1'b1);
      check({tag, "_dr"}, data_ready, 1'b0);
      exp_fe++;
    end
    check_outputs(tag);
    idle(1);
    check({tag, "_dr_end"}, data_ready, 1'b0);
    check({tag, "_fe_end"}, frame_error, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic directed_payload();
    logic [7:0] s0 [BPS];
    s0 = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00,
           8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h0C, 8'h08};
    for (int i = 0; i < BPS; i++) begin
      pay[i]       = s0[i];
      pay[BPS + i] = 8'h11;
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk_162);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_dr", data_ready, 1'b0);
    check("rst_fe", frame_error, 1'b0);
    check("rst_rdy_in_reset", rx_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_rdy_after", rx_ready, 1'b1);
    check_outputs("rst");

    directed_payload();
    set_gaps(0);
    send_frame("valid", 8'h00);
    check("valid_loc00", init_locations[0][0], 32'h0000_0100);
    check("valid_loc01", init_locations[0][1], 32'h0000_0200);
    check("valid_velo00", init_velos[0][0], 32'hFFFF_FFF0);
    check("valid_mass0", masses[0], 16'h0C00);
    check("valid_mass1", masses[1], 16'h1111);
    check("valid_rad1", radii[1], 7'h11);

    send_frame("badck", 8'h01);

    send_byte(8'h00);
    send_byte(8'h37);
    random_payload();
    set_gaps(1);
    send_frame("junk_toggle", 8'h00);

    random_payload();
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(pay[i]);
    idle(99);
    check("to_early_fe", frame_error, 1'b0);
    check("to_early_busy", busy, 1'b1);
    idle(1);
    check("to_pulse", frame_error, 1'b1);
    exp_fe++;
    idle(1);
    check("to_pulse_end", frame_error, 1'b0);
    check("to_busy", busy, 1'b0);
    check_outputs("to_hold");
    random_payload();
    set_gaps(0);
    send_frame("after_to", 8'h00);

    random_payload();
    send_byte(8'hA5);
    for (int i = 0; i < 20; i++) send_byte(pay[i]);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", rx_ready, 1'b0);
    @(posedge clk_162);
    #1;
    rst = 1'b0;
    model_reset();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dr", data_ready, 1'b0);
    check("mid_rst_fe", frame_error, 1'b0);
    check_outputs("mid_rst");
    idle(3);
    directed_payload();
    set_gaps(0);
    send_frame("after_rst", 8'h00);

    random_payload();
    set_gaps(0);
    gaps[0]    = TIMEOUT - 1;
    gaps[15]   = TIMEOUT - 1;
    gaps[NPAY] = TIMEOUT - 1;
    send_frame("edge_to", 8'h00);

    for (int r = 0; r < 12; r++) begin
      logic [7:0] junk;
      logic [7:0] flip;
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      random_payload();
      set_gaps(2);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame($sformatf("rnd%0d", r), flip);
    end

    idle(5);
    check("dr_pulse_count", 64'(dr_cnt), 64'(exp_dr));
    check("fe_pulse_count", 64'(fe_cnt), 64'(exp_fe));
    check("dr_fe_overlap", 64'(both_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
